// File: rtl/booth_multiplier_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : booth_multiplier_seq_pkg
// Brief  : Shared types and Booth encoding constants for the MUL datapath.
// Rev    : 1.0
// ============================================================================
package booth_multiplier_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] PP_ZERO = 3'd0;
    localparam logic [2:0] PP_POS1 = 3'd1;
    localparam logic [2:0] PP_POS2 = 3'd2;
    localparam logic [2:0] PP_NEG1 = 3'd3;
    localparam logic [2:0] PP_NEG2 = 3'd4;

    // Maps the bit-pair window {q1, q0, q_m1} onto a partial-product selector.
    function automatic logic [2:0] booth_decode(input logic [2:0] sel);
        logic [2:0] code;
        case (sel)
            3'b000, 3'b111: code = PP_ZERO;
            3'b001, 3'b010: code = PP_POS1;
            3'b011:         code = PP_POS2;
            3'b100:         code = PP_NEG2;
            default:        code = PP_NEG1;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_multiplier_seq_pp_select.sv
`default_nettype none
// ============================================================================
// Module : booth_pp_select
// Brief  : Radix-4 Booth partial-product generator (0, +-M, +-2M).
// Rev    : 1.0
// ============================================================================
module booth_pp_select
    import booth_multiplier_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       sel_i,
    input  logic [WIDTH+1:0] m_ext_i,
    output logic [WIDTH+1:0] pp_o
);

    logic [WIDTH+1:0] w_m2;

    // Two guard bits keep 2M exact even for the most negative multiplicand.
    assign w_m2 = {m_ext_i[WIDTH:0], 1'b0};

    always_comb begin
        pp_o = '0;
        case (booth_decode(sel_i))
            PP_POS1: pp_o = m_ext_i;
            PP_POS2: pp_o = w_m2;
            PP_NEG1: pp_o = '0 - m_ext_i;
            PP_NEG2: pp_o = '0 - w_m2;
            default: pp_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module : booth_multiplier_seq
// Brief  : Sequential signed radix-4 Booth multiplier, two bits per clock.
// Rev    : 1.0
// ============================================================================
module booth_multiplier_seq
    import booth_multiplier_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_hi_o,
    output logic [WIDTH-1:0] product_lo_o
);

    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = WIDTH + 2;
    localparam int SW = AW + WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    m_q, m_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [AW-1:0]    w_pp;
    logic [AW-1:0]    w_sum;
    logic [SW-1:0]    w_shift;

    booth_pp_select #(
        .WIDTH   (WIDTH)
    ) u_pp_select (
        .sel_i   ({q_q[1:0], qm1_q}),
        .m_ext_i (m_q),
        .pp_o    (w_pp)
    );

    assign w_sum   = acc_q + w_pp;
    assign w_shift = $signed({w_sum, q_q, qm1_q}) >>> 2;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    state_d = ST_RUN;
                    m_d     = {{2{multiplicand_i[WIDTH-1]}}, multiplicand_i};
                    acc_d   = '0;
                    q_d     = multiplier_i;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                acc_d = w_shift[SW-1 -: AW];
                q_d   = w_shift[WIDTH:1];
                qm1_d = w_shift[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Product is taken from the post-iteration value so it lands with done.
                    state_d = ST_DONE;
                    hi_d    = w_shift[SW-3 -: WIDTH];
                    lo_d    = w_shift[WIDTH:1];
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign product_hi_o = hi_q;
    assign product_lo_o = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_booth_multiplier_seq
// Brief  : Directed-vector bench for booth_multiplier_seq at WIDTH = 32.
// Rev    : 1.0
// ============================================================================
module tb_booth_multiplier_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clear;
    logic         start;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[10];

    booth_multiplier_seq #(
        .WIDTH          (W)
    ) dut (
        .clock_i        (clk),
        .clear_i        (clear),
        .start_i        (start),
        .multiplicand_i (mcand),
        .multiplier_i   (mplier),
        .busy_o         (busy),
        .done_o         (done),
        .product_hi_o   (hi),
        .product_lo_o   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a start, then waits (bounded) for done; lat counts edges after the start edge.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt, output int ovl);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 0;
        bcnt   = 0;
        ovl    = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        if (busy && done) ovl++;
    endtask

    initial begin
        int lat, bcnt, ovl, ndone, dlat, nd;
        logic [W-1:0] rhi, rlo, ra, rb;
        logic signed [63:0] sa, sb, prod;

        clear  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        clear = 1'b0;
        tick();

        vecs[0] = '{32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};
        vecs[4] = '{32'd5,        32'd6,         32'd0,         32'd30};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[6] = '{32'd0,        32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[9] = '{32'd12,       32'd12,        32'd0,         32'd144};

        for (int i = 0; i < 10; i++) begin
            do_mul(vecs[i].a, vecs[i].b, lat, bcnt, ovl);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd16);
            check($sformatf("vec%0d_busy_done_overlap", i), 64'(ovl), 64'd0);
            tick();
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_hold_lo", i), 64'(lo), 64'(vecs[i].lo));
        end

        for (int i = 0; i < 8; i++) begin
            ra   = $urandom();
            rb   = $urandom();
            sa   = $signed(ra);
            sb   = $signed(rb);
            prod = sa * sb;
            do_mul(ra, rb, lat, bcnt, ovl);
            check($sformatf("rand%0d_hi", i), 64'(hi), 64'(prod[63:32]));
            check($sformatf("rand%0d_lo", i), 64'(lo), 64'(prod[31:0]));
            tick();
        end

        // Operand changes and stray starts while RUN must not disturb the latched job.
        mcand  = 32'h0000_FFFF;
        mplier = 32'h0000_FFFF;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        ndone  = 0;
        dlat   = -1;
        rhi    = '0;
        rlo    = '0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                ndone++;
                if (dlat < 0) dlat = c - 1;
                rhi = hi;
                rlo = lo;
            end
            start = (c == 3 || c == 9);
            if (c == 3) begin
                mcand  = 32'h1234_5678;
                mplier = 32'h8765_4321;
            end
            if (c == 9) begin
                mcand  = 32'd7;
                mplier = 32'd3;
            end
            tick();
        end
        start = 1'b0;
        check("midrun_done_count", 64'(ndone), 64'd1);
        check("midrun_latency", 64'(dlat), 64'd16);
        check("midrun_hi", 64'(rhi), 64'd0);
        check("midrun_lo", 64'(rlo), 64'hFFFE_0001);

        mcand  = 32'd7;
        mplier = 32'hFFFF_FFFD;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (7) tick();
        check("abort_busy_before", 64'(busy), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        nd = 0;
        repeat (30) begin
            if (done || busy) nd++;
            tick();
        end
        check("abort_no_activity", 64'(nd), 64'd0);
        do_mul(32'd5, 32'd6, lat, bcnt, ovl);
        check("after_abort_lo", 64'(lo), 64'd30);
        check("after_abort_hi", 64'(hi), 64'd0);
        check("after_abort_latency", 64'(lat), 64'd16);
        tick();

        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, ovl);
        check("b2b_first_done", 64'(done), 64'd1);
        check("b2b_first_lo", 64'(lo), 64'd1);
        check("b2b_first_hi", 64'(hi), 64'd0);
        do_mul(32'd12, 32'd12, lat, bcnt, ovl);
        check("b2b_gap", 64'(lat + 1), 64'd17);
        check("b2b_second_lo", 64'(lo), 64'd144);
        check("b2b_second_hi", 64'(hi), 64'd0);
        tick();
        check("b2b_done_pulse", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
